// File: rtl/regfile_bypass_sb_if.sv
// Decode-side bundle for the bypassing register file: select/write/claim inputs,
// read data, busy flags, flattened register view and the error pulse.
interface regfile_bypass_sb_if #(
   parameter int NREG  = 8,
   parameter int WDATA = 16,
   parameter int WSEL  = 3
);
   logic [WSEL-1:0]       read1RegSel;
   logic [WSEL-1:0]       read2RegSel;
   logic [WSEL-1:0]       writeRegSel;
   logic [WDATA-1:0]      writeData;
   logic                  writeEn;
   logic                  claimEn;
   logic [WSEL-1:0]       claimSel;
   logic [WDATA-1:0]      read1Data;
   logic [WDATA-1:0]      read2Data;
   logic                  read1Busy;
   logic                  read2Busy;
   logic [NREG*WDATA-1:0] allRegs;
   logic [NREG-1:0]       busy;
   logic                  err;

   modport master (
      output read1RegSel, read2RegSel, writeRegSel, writeData, writeEn, claimEn, claimSel,
      input  read1Data, read2Data, read1Busy, read2Busy, allRegs, busy, err
   );

   modport slave (
      input  read1RegSel, read2RegSel, writeRegSel, writeData, writeEn, claimEn, claimSel,
      output read1Data, read2Data, read1Busy, read2Busy, allRegs, busy, err
   );
endinterface

// File: rtl/regfile_bypass_sb.sv
// 8x16 register file with two combinational read ports, optional write bypass,
// and a per-register busy scoreboard used by decode to stall on RAW hazards.
module regfile_bypass_sb #(
   parameter int NREG   = 8,
   parameter int WDATA  = 16,
   parameter int WSEL   = 3,
   parameter int BYPASS = 1
) (
   input  logic               clk,
   input  logic               rst,
   regfile_bypass_sb_if.slave bus
);
   logic [WDATA-1:0] regs_q [NREG];
   logic [WDATA-1:0] regs_d [NREG];
   logic [NREG-1:0]  busy_q, busy_d;
   logic             err_q, err_d;

   // Writes and claims are inert while reset is held, including their bypass effect.
   logic wr_en, cl_en;
   assign wr_en = bus.writeEn & rst;
   assign cl_en = bus.claimEn & rst;

   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (wr_en) begin
         regs_d[bus.writeRegSel] = bus.writeData;
         busy_d[bus.writeRegSel] = 1'b0;
      end
      // Claim applied last so a new producer supersedes a retiring one.
      if (cl_en) busy_d[bus.claimSel] = 1'b1;
      err_d = (cl_en && busy_q[bus.claimSel]) || (wr_en && !busy_q[bus.writeRegSel]);
   end

   // NOTE: the array is reset too, since allRegs must read all zeros while rst is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   logic fwd1, fwd2;
   assign fwd1 = (BYPASS != 0) && wr_en && (bus.writeRegSel == bus.read1RegSel);
   assign fwd2 = (BYPASS != 0) && wr_en && (bus.writeRegSel == bus.read2RegSel);

   assign bus.read1Data = fwd1 ? bus.writeData : regs_q[bus.read1RegSel];
   assign bus.read2Data = fwd2 ? bus.writeData : regs_q[bus.read2RegSel];

   // A retiring write hides the busy bit unless the same register is re-claimed this cycle.
   assign bus.read1Busy = busy_q[bus.read1RegSel] &
                          ~(fwd1 & ~(cl_en && (bus.claimSel == bus.read1RegSel)));
   assign bus.read2Busy = busy_q[bus.read2RegSel] &
                          ~(fwd2 & ~(cl_en && (bus.claimSel == bus.read2RegSel)));

   for (genvar g = 0; g < NREG; g++) begin : g_flat
      assign bus.allRegs[g*WDATA +: WDATA] = regs_q[g];
   end

   assign bus.busy = busy_q;
   assign bus.err  = err_q;
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Scoreboard bench: stimulus queues expected values, a monitor process pops and
// compares them against the bypassing DUT and a BYPASS=0 twin sharing its inputs.
module tb_regfile_bypass_sb;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   regfile_bypass_sb_if bus ();
   regfile_bypass_sb_if bus_nb ();

   regfile_bypass_sb #(.BYPASS(1)) dut    (.clk(clk), .rst(rst), .bus(bus));
   regfile_bypass_sb #(.BYPASS(0)) dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

   assign bus_nb.read1RegSel = bus.read1RegSel;
   assign bus_nb.read2RegSel = bus.read2RegSel;
   assign bus_nb.writeRegSel = bus.writeRegSel;
   assign bus_nb.writeData   = bus.writeData;
   assign bus_nb.writeEn     = bus.writeEn;
   assign bus_nb.claimEn     = bus.claimEn;
   assign bus_nb.claimSel    = bus.claimSel;

   localparam int S_R1 = 0, S_R2 = 1, S_B1 = 2, S_B2 = 3, S_ALL = 4, S_BUSY = 5,
                  S_ERR = 6, S_NB_R2 = 7, S_NB_B2 = 8, S_SLICE = 9;

   typedef struct {
      string        name;
      int           sel;
      int           idx;
      logic [127:0] exp;
   } exp_t;

   exp_t sb_q[$];
   event check_ev;
   int   checks = 0;
   int   errors = 0;

   function automatic logic [127:0] observe(int sel, int idx);
      case (sel)
         S_R1:    return 128'(bus.read1Data);
         S_R2:    return 128'(bus.read2Data);
         S_B1:    return 128'(bus.read1Busy);
         S_B2:    return 128'(bus.read2Busy);
         S_ALL:   return bus.allRegs;
         S_BUSY:  return 128'(bus.busy);
         S_ERR:   return 128'(bus.err);
         S_NB_R2: return 128'(bus_nb.read2Data);
         S_NB_B2: return 128'(bus_nb.read2Busy);
         default: return 128'(bus.allRegs[idx*16 +: 16]);
      endcase
   endfunction

   initial begin : monitor
      exp_t e;
      logic [127:0] got;
      forever begin
         @(check_ev);
         while (sb_q.size() != 0) begin
            e   = sb_q.pop_front();
            got = observe(e.sel, e.idx);
            checks++;
            if (got !== e.exp) begin
               errors++;
               $display("FAIL %s: got %0h expected %0h", e.name, got, e.exp);
            end
         end
      end
   end

   task automatic ex(input string name, input int sel, input logic [127:0] v, input int idx = 0);
      exp_t e;
      e.name = name; e.sel = sel; e.idx = idx; e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic flush();
      -> check_ev;
      #1;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL monitor_stall: got %0d pending expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic idle();
      bus.writeEn = 1'b0;
      bus.claimEn = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic claim(input int r);
      bus.claimEn = 1'b1; bus.claimSel = 3'(r);
   endtask

   task automatic write(input int r, input logic [15:0] d);
      bus.writeEn = 1'b1; bus.writeRegSel = 3'(r); bus.writeData = d;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin : stim
      logic [7:0] bexp;
      bus.read1RegSel = '0; bus.read2RegSel = '0; bus.writeRegSel = '0;
      bus.writeData = '0; bus.claimSel = '0;
      idle();
      #1;
      ex("rst_all", S_ALL, 0); ex("rst_busy", S_BUSY, 0); ex("rst_err", S_ERR, 0);
      flush();
      @(negedge clk);
      rst = 1'b1;

      // Claim R2, then retire it with a write.
      claim(2); tick(); idle(); #1;
      ex("claim2_busy", S_BUSY, 8'h04); ex("claim2_err", S_ERR, 0); flush();
      write(2, 16'h1234); tick(); idle();
      bus.read1RegSel = 3'd2; #1;
      ex("wr2_read1", S_R1, 16'h1234); ex("wr2_slice", S_SLICE, 16'h1234, 2);
      ex("wr2_busy", S_BUSY, 0); ex("wr2_err", S_ERR, 0); flush();

      // R4 = 0001, then a same-cycle write is forwarded only on the bypass DUT.
      claim(4); tick(); idle();
      write(4, 16'h0001); tick(); idle();
      write(4, 16'hA5A5); bus.read2RegSel = 3'd4; #1;
      ex("byp_read2", S_R2, 16'hA5A5); ex("byp_slice", S_SLICE, 16'h0001, 4);
      ex("nobyp_read2", S_NB_R2, 16'h0001); flush();
      idle(); #1;
      ex("byp_cancel_read2", S_R2, 16'h0001); flush();

      // Busy masking by a retiring write, and re-claim overriding the mask.
      claim(4); tick(); idle();
      write(4, 16'hA5A5); #1;
      ex("byp_busy_mask", S_B2, 0); ex("nobyp_busy", S_NB_B2, 1); flush();
      claim(4); #1;
      ex("byp_busy_reclaim", S_B2, 1); flush();
      bus.claimEn = 1'b0; tick(); idle(); #1;
      ex("byp_retire_busy", S_BUSY, 0); ex("byp_retire_err", S_ERR, 0);
      ex("byp_retire_slice", S_SLICE, 16'hA5A5, 4); flush();

      // Claim/write collision on R6: set wins, double claim flags err.
      claim(6); tick(); idle();
      claim(6); write(6, 16'h00FF); tick(); idle(); #1;
      ex("coll_busy", S_BUSY, 8'h40); ex("coll_slice", S_SLICE, 16'h00FF, 6);
      ex("coll_err", S_ERR, 1); flush();
      tick(); #1;
      ex("coll_err_pulse", S_ERR, 0); flush();
      write(6, 16'h00FF); tick(); idle(); #1;
      ex("coll_retire_busy", S_BUSY, 0); ex("coll_retire_err", S_ERR, 0); flush();

      // Unclaimed write: performed, err pulses for one cycle.
      write(1, 16'h7777); tick(); idle(); #1;
      ex("unclaimed_slice", S_SLICE, 16'h7777, 1); ex("unclaimed_err", S_ERR, 1); flush();
      tick(); #1;
      ex("unclaimed_err_clear", S_ERR, 0); flush();

      // Mid-run asynchronous reset with R3 written and R5 claimed.
      claim(3); tick(); idle();
      write(3, 16'hBEEF); tick(); idle();
      claim(5); tick(); idle(); #1;
      ex("pre_rst_slice", S_SLICE, 16'hBEEF, 3); ex("pre_rst_busy", S_BUSY, 8'h20); flush();
      rst = 1'b0;
      bus.read1RegSel = 3'd3;
      write(3, 16'h1111); claim(3); #1;
      ex("mid_rst_all", S_ALL, 0); ex("mid_rst_busy", S_BUSY, 0);
      ex("mid_rst_err", S_ERR, 0); ex("mid_rst_read1", S_R1, 0); flush();
      tick(); #1;
      ex("mid_rst_hold_all", S_ALL, 0); ex("mid_rst_hold_busy", S_BUSY, 0); flush();
      idle(); rst = 1'b1;

      // Sweep: claim R(i) while retiring R(i-1) in the same cycle.
      for (int i = 0; i <= 8; i++) begin
         bus.claimEn = (i < 8); bus.claimSel = 3'(i);
         bus.writeEn = (i > 0); bus.writeRegSel = 3'(i - 1);
         bus.writeData = 16'(16'h1111 * i);
         tick(); idle(); #1;
         bexp = (i < 8) ? 8'(1 << i) : 8'h00;
         ex($sformatf("sweep_busy_%0d", i), S_BUSY, bexp);
         ex($sformatf("sweep_err_%0d", i), S_ERR, 0);
         flush();
      end
      bus.read1RegSel = 3'd7; bus.read2RegSel = 3'd0; #1;
      ex("sweep_all", S_ALL, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
      ex("sweep_read1", S_R1, 16'h8888); ex("sweep_read2", S_R2, 16'h1111);
      flush();

      #20;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
